// File: rtl/id_stage.sv
// id_stage: registered, valid/ready RV32I decode stage that serialises CSR and FENCE.I instructions.
// Define ID_ILLEGAL_CHECK_EN to enable illegal-encoding detection on illegal_o.
module id_stage #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              flush,
    input  logic              ser_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              rd_we_o,
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic              csr_we_o,
    output logic              imm_en_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [2:0]        funct3_o,
    output logic              alt_o,
    output logic              un_signed_o,
    output logic              illegal_o
);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

`ifdef ID_ILLEGAL_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef enum logic {RUN, WAIT_SER} state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              rd_we;
        logic [CSR_AW-1:0] csr_addr;
        logic              csr_we;
        logic              imm_en;
        logic [DATA_W-1:0] imm;
        logic [2:0]        funct3;
        logic              alt;
        logic              un_signed;
        logic              illegal;
    } bundle_t;

    state_e      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    bundle_t     bundle_q, bundle_d, dec;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        use_rs1, use_rs2, use_rd, use_imm, is_csr, is_fence_i;
    logic        known, bad_enc, uns, alt, illegal, serial, accept;
    logic [DATA_W-1:0] imm;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // NOTE: every signal written here gets a default first, so no decode path can infer a latch.
    always_comb begin
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        use_rd     = 1'b0;
        use_imm    = 1'b0;
        is_csr     = 1'b0;
        is_fence_i = 1'b0;
        known      = 1'b1;
        bad_enc    = 1'b0;
        uns        = 1'b0;
        alt        = 1'b0;
        imm        = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                use_rd  = 1'b1;
                use_imm = 1'b1;
                imm     = DATA_W'($signed({inst[31:12], 12'b0}));
            end
            OPC_JAL: begin
                use_rd  = 1'b1;
                use_imm = 1'b1;
                imm     = DATA_W'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            end
            OPC_JALR: begin
                {use_rs1, use_rd, use_imm} = 3'b111;
                imm     = DATA_W'($signed(inst[31:20]));
                bad_enc = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                {use_rs1, use_rs2} = 2'b11;
                imm     = DATA_W'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
                uns     = funct3[2] & funct3[1];
                bad_enc = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                {use_rs1, use_rd, use_imm} = 3'b111;
                imm     = DATA_W'($signed(inst[31:20]));
                uns     = funct3[2] & ~funct3[1];
                bad_enc = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                {use_rs1, use_rs2, use_imm} = 3'b111;
                imm     = DATA_W'($signed({inst[31:25], inst[11:7]}));
                bad_enc = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                {use_rs1, use_rd, use_imm} = 3'b111;
                imm     = DATA_W'($signed(inst[31:20]));
                uns     = (funct3 == 3'b011);
                alt     = (funct3 == 3'b101) & inst[30];
                bad_enc = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                          ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
            end
            OPC_OP: begin
                {use_rs1, use_rs2, use_rd} = 3'b111;
                uns     = (funct3 == 3'b011);
                alt     = inst[30];
                bad_enc = (funct7 != 7'h00) &&
                          !((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_MISC_MEM: begin
                is_fence_i = (funct3 == 3'b001);
                bad_enc    = (funct3 > 3'b001);
            end
            OPC_SYSTEM: begin
                // funct3 000 is ECALL/EBREAK: legal, but touches no registers.
                if (funct3 != 3'b000 && funct3 != 3'b100) begin
                    is_csr  = 1'b1;
                    use_rd  = 1'b1;
                    use_rs1 = ~funct3[2];
                    use_imm = funct3[2];
                    imm     = funct3[2] ? DATA_W'(inst[19:15]) : '0;
                end
                bad_enc = (funct3 == 3'b100);
            end
            default: known = 1'b0;
        endcase
    end

    assign illegal = CHK_EN & (!known || bad_enc || (inst[1:0] != 2'b11) || (inst[31:0] == 32'h0));
    assign serial  = !illegal && (is_csr || is_fence_i);

    always_comb begin
        dec           = '0;
        dec.pc        = inst_addr;
        dec.rs1       = use_rs1 ? REG_AW'(inst[19:15]) : '0;
        dec.rs2       = use_rs2 ? REG_AW'(inst[24:20]) : '0;
        dec.rd        = use_rd ? REG_AW'(inst[11:7]) : '0;
        dec.rd_we     = use_rd && (inst[11:7] != 5'd0) && !illegal;
        dec.csr_addr  = is_csr ? CSR_AW'(inst[31:20]) : '0;
        dec.csr_we    = is_csr && !illegal && ((funct3[1:0] == 2'b01) || (inst[19:15] != 5'd0));
        dec.imm_en    = use_imm;
        dec.imm       = imm;
        dec.funct3    = funct3;
        dec.alt       = alt;
        dec.un_signed = uns;
        dec.illegal   = illegal;
    end

    assign in_ready = !rst && (state_q == RUN) && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        case (state_q)
            RUN:      if (accept && serial) state_d = WAIT_SER;
            WAIT_SER: if (ser_done) state_d = RUN;
            default:  state_d = RUN;
        endcase
        if (out_ready) out_valid_d = 1'b0;
        if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
        end
        // Flush outranks both accept (already blocked via in_ready) and ser_done.
        if (flush) begin
            state_d     = RUN;
            out_valid_d = 1'b0;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign inst_addr_o = bundle_q.pc;
    assign rs1_addr_o  = bundle_q.rs1;
    assign rs2_addr_o  = bundle_q.rs2;
    assign rd_addr_o   = bundle_q.rd;
    assign rd_we_o     = bundle_q.rd_we;
    assign csr_addr_o  = bundle_q.csr_addr;
    assign csr_we_o    = bundle_q.csr_we;
    assign imm_en_o    = bundle_q.imm_en;
    assign imm_o       = bundle_q.imm;
    assign funct3_o    = bundle_q.funct3;
    assign alt_o       = bundle_q.alt;
    assign un_signed_o = bundle_q.un_signed;
    assign illegal_o   = bundle_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed checks of id_stage followed by randomized traffic against a scoreboard model.
// Honours ID_ILLEGAL_CHECK_EN for the expected illegal_o behaviour.
module tb_id_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [11:0] csr;
        logic        csr_we;
        logic        imm_en;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        alt;
        logic        uns;
        logic        ill;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, ser_done, out_valid, out_ready;
    logic [31:0] inst, inst_addr, inst_addr_o, imm_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [11:0] csr_addr_o;
    logic [2:0]  funct3_o;
    logic        rd_we_o, csr_we_o, imm_en_o, alt_o, un_signed_o, illegal_o;
    bundle_t     obs;

    int          n_tests = 0;
    int          n_fail  = 0;
    bundle_t     sb[$];
    bit          pend = 1'b0;
    logic [6:0]  opc_tab [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                  7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};

    id_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .inst_addr(inst_addr), .flush(flush), .ser_done(ser_done),
        .out_valid(out_valid), .out_ready(out_ready), .inst_addr_o(inst_addr_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .rd_we_o(rd_we_o), .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o),
        .imm_en_o(imm_en_o), .imm_o(imm_o), .funct3_o(funct3_o), .alt_o(alt_o),
        .un_signed_o(un_signed_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    assign obs = {inst_addr_o, rs1_addr_o, rs2_addr_o, rd_addr_o, rd_we_o, csr_addr_o,
                  csr_we_o, imm_en_o, imm_o, funct3_o, alt_o, un_signed_o, illegal_o};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    // Sign-extend the low n bits of v arithmetically.
    function automatic logic [31:0] sx(input logic [31:0] v, input int n);
        return v[n-1] ? v - (32'd1 << n) : v;
    endfunction

    function automatic void ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                       output bundle_t b, output bit ser);
        logic [6:0] opc = i[6:0];
        logic [6:0] f7  = i[31:25];
        logic [2:0] f3  = i[14:12];
        bit lui = opc == 7'h37, auipc = opc == 7'h17, jal = opc == 7'h6F, jalr = opc == 7'h67;
        bit br = opc == 7'h63, ld = opc == 7'h03, st = opc == 7'h23, opi = opc == 7'h13;
        bit op = opc == 7'h33, misc = opc == 7'h0F, sys = opc == 7'h73;
        bit csr_r = sys && (f3 inside {3'd1, 3'd2, 3'd3});
        bit csr_i = sys && (f3 inside {3'd5, 3'd6, 3'd7});
        bit ill = 1'b0;
`ifdef ID_ILLEGAL_CHECK_EN
        ill = (i == 32'h0) || (i[1:0] != 2'b11) ||
              !(lui || auipc || jal || jalr || br || ld || st || opi || op || misc || sys) ||
              (jalr && f3 != 0) || (br && (f3 == 2 || f3 == 3)) ||
              (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 > 2) ||
              (misc && f3 > 1) || (sys && f3 == 4) ||
              (opi && f3 == 1 && f7 != 0) || (opi && f3 == 5 && f7 != 0 && f7 != 7'h20) ||
              (op && f7 != 0 && !(f7 == 7'h20 && (f3 == 0 || f3 == 5)));
`endif
        b = '0;
        b.pc = pc;
        b.f3 = f3;
        if (jalr || br || ld || st || opi || op || csr_r) b.rs1 = i[19:15];
        if (br || st || op) b.rs2 = i[24:20];
        if (lui || auipc || jal || jalr || ld || opi || op || csr_r || csr_i) b.rd = i[11:7];
        b.rd_we = (b.rd != 0) && !ill;
        if (csr_r || csr_i) b.csr = i[31:20];
        b.csr_we = (csr_r || csr_i) && !ill && (f3[1:0] == 2'b01 || i[19:15] != 0);
        b.imm_en = lui || auipc || jal || jalr || ld || st || opi || csr_i;
        if (lui || auipc)          b.imm = {i[31:12], 12'h000};
        else if (jal)              b.imm = sx({i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
        else if (br)               b.imm = sx({i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
        else if (st)               b.imm = sx({i[31:25], i[11:7]}, 12);
        else if (jalr || ld || opi) b.imm = sx(i[31:20], 12);
        else if (csr_i)            b.imm = i[19:15];
        b.alt = op ? i[30] : (opi && f3 == 5) ? i[30] : 1'b0;
        b.uns = (br && f3 >= 6) || (ld && (f3 == 4 || f3 == 5)) || ((opi || op) && f3 == 3);
        b.ill = ill;
        ser = !ill && (csr_r || csr_i || (misc && f3 == 1));
    endfunction

    // One cycle of randomized (or draining) traffic checked against the scoreboard queue.
    task automatic rand_cycle(input bit drain);
        logic [31:0] i, a;
        bit          iv, ordy, fl, sd, exp_rdy, s;
        bundle_t     b;
        check("rv_valid", out_valid, sb.size() != 0);
        if (sb.size() != 0) check("rv_bundle", obs, sb[0]);
        i = $urandom;
        a = $urandom;
        begin
            int k = $urandom_range(0, 11);
            if (k != 11) i[6:0] = opc_tab[k];
        end
        if ($urandom_range(0, 3) == 0) i[19:15] = 5'd0;
        if ($urandom_range(0, 3) == 0) i[11:7] = 5'd0;
        if ($urandom_range(0, 1) == 1) i[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if (drain) begin
            iv = 0; ordy = 1; fl = 0; sd = 1;
        end else begin
            iv   = $urandom_range(0, 9) < 7;
            ordy = $urandom_range(0, 3) != 0;
            fl   = $urandom_range(0, 19) == 0;
            sd   = $urandom_range(0, 3) == 0;
        end
        in_valid = iv; inst = i; inst_addr = a; out_ready = ordy; flush = fl; ser_done = sd;
        #1;
        exp_rdy = !pend && (sb.size() == 0 || ordy) && !fl;
        check("rv_ready", in_ready, exp_rdy);
        if (fl) begin
            sb.delete();
            pend = 1'b0;
        end else begin
            if (sb.size() != 0 && ordy) void'(sb.pop_front());
            if (pend && sd) pend = 1'b0;
            if (iv && exp_rdy) begin
                ref_decode(i, a, b, s);
                sb.push_back(b);
                pend = s;
            end
        end
        next();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; in_valid = 0; inst = 0; inst_addr = 0; flush = 0; ser_done = 0; out_ready = 0;
        #1 check("rst_ready_pre", in_ready, 0);
        next();
        check("rst_valid", out_valid, 0);
        check("rst_bundle", obs, 0);
        check("rst_ready", in_ready, 0);
        next();
        rst = 0;
        #1 check("run_ready", in_ready, 1);

        // ADDI x5,x1,-1
        in_valid = 1; inst = 32'hFFF08293; inst_addr = 32'h100; out_ready = 1;
        next();
        in_valid = 0;
        check("addi_valid", out_valid, 1);
        check("addi_rd", rd_addr_o, 5);
        check("addi_rs1", rs1_addr_o, 1);
        check("addi_rs2", rs2_addr_o, 0);
        check("addi_imm", imm_o, 32'hFFFFFFFF);
        check("addi_imm_en", imm_en_o, 1);
        check("addi_rd_we", rd_we_o, 1);
        check("addi_pc", inst_addr_o, 32'h100);
        next();
        check("addi_drained", out_valid, 0);

        // Backpressure: ADD x3,x1,x2 held while SUB x4,x5,x6 waits
        in_valid = 1; inst = 32'h002081B3; inst_addr = 32'h200; out_ready = 0;
        next();
        inst = 32'h40628233; inst_addr = 32'h204;
        for (int c = 0; c < 3; c++) begin
            #1 check("bp_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_rd", rd_addr_o, 3);
            check("bp_pc", inst_addr_o, 32'h200);
            if (c < 2) next();
        end
        out_ready = 1;
        #1 check("bp_release", in_ready, 1);
        next();
        in_valid = 0;
        check("bp_second_pc", inst_addr_o, 32'h204);
        check("bp_second_rd", rd_addr_o, 4);
        check("bp_second_alt", alt_o, 1);
        check("bp_second_rs2", rs2_addr_o, 6);
        next();
        check("bp_no_dup", out_valid, 0);

        // CSRRS x3,mstatus,x0 serialises until ser_done
        in_valid = 1; inst = 32'h300021F3; inst_addr = 32'h300;
        next();
        inst = 32'hFFF08293; inst_addr = 32'h304;
        check("csr_valid", out_valid, 1);
        check("csr_we", csr_we_o, 0);
        check("csr_addr", csr_addr_o, 12'h300);
        check("csr_rd_we", rd_we_o, 1);
        check("csr_rs1", rs1_addr_o, 0);
        #1 check("csr_wait_ready", in_ready, 0);
        next();
        ser_done = 1;
        #1 check("csr_done_cycle_ready", in_ready, 0);
        next();
        ser_done = 0;
        #1 check("csr_after_done_ready", in_ready, 1);
        next();
        in_valid = 0;
        check("csr_next_pc", inst_addr_o, 32'h304);
        next();

        // BLTU x1,x2,-4
        in_valid = 1; inst = 32'hFE20EEE3; inst_addr = 32'h400;
        next();
        in_valid = 0;
        check("bltu_imm", imm_o, 32'hFFFFFFFC);
        check("bltu_uns", un_signed_o, 1);
        check("bltu_rd_we", rd_we_o, 0);
        check("bltu_rs1", rs1_addr_o, 1);
        check("bltu_rs2", rs2_addr_o, 2);
        check("bltu_imm_en", imm_en_o, 0);
        next();

        // Flush during WAIT_SER with a held bundle (CSRRW x1,0x305,x2)
        in_valid = 1; inst = 32'h305110F3; inst_addr = 32'h500; out_ready = 0;
        next();
        inst = 32'hFFF08293; inst_addr = 32'h504;
        check("fl_valid", out_valid, 1);
        check("fl_csr_we", csr_we_o, 1);
        check("fl_csr_addr", csr_addr_o, 12'h305);
        #1 check("fl_wait_ready", in_ready, 0);
        flush = 1; ser_done = 1;
        #1 check("fl_ready", in_ready, 0);
        next();
        flush = 0; ser_done = 0; in_valid = 0; out_ready = 1;
        check("fl_cleared", out_valid, 0);
        #1 check("fl_run", in_ready, 1);
        next();
        check("fl_no_accept", out_valid, 0);

        // All-ones opcode 0x7F
        in_valid = 1; inst = 32'h0000007F; inst_addr = 32'h600;
        next();
        in_valid = 0;
`ifdef ID_ILLEGAL_CHECK_EN
        check("ill_flag", illegal_o, 1);
`else
        check("ill_flag", illegal_o, 0);
`endif
        check("ill_rd_we", rd_we_o, 0);
        next();

        for (int n = 0; n < 3000; n++) rand_cycle(1'b0);
        for (int n = 0; n < 20; n++) rand_cycle(1'b1);
        check("drain_valid", out_valid, 0);
        #1 check("drain_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
